// File: rtl/taxi_dma_ram_demux_rd_cr.sv
// Per-segment DMA RAM read demux: routes client reads to one of PORTS RAMs and returns data in command order.
// Output FIFO space is reserved with a credit at command accept, so RAM responses are never back-pressured.
module taxi_dma_ram_demux_rd_cr #(
  parameter int PORTS            = 4,
  parameter int SEG_ADDR_W       = 12,
  parameter int SEG_DATA_W       = 64,
  parameter int DMA_SEL_W        = 4,
  parameter int RAM_SEL_W        = 2,
  parameter int ORDER_FIFO_DEPTH = 32,
  parameter int OUT_FIFO_DEPTH   = 16,
  parameter int MAX_OUTSTANDING  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DMA_SEL_W-1:0]          s_cmd_sel,
  input  logic [SEG_ADDR_W-1:0]         s_cmd_addr,
  input  logic                          s_cmd_valid,
  output logic                          s_cmd_ready,
  output logic [SEG_DATA_W-1:0]         s_resp_data,
  output logic                          s_resp_valid,
  input  logic                          s_resp_ready,
  output logic [PORTS*RAM_SEL_W-1:0]    m_cmd_sel,
  output logic [PORTS*SEG_ADDR_W-1:0]   m_cmd_addr,
  output logic [PORTS-1:0]              m_cmd_valid,
  input  logic [PORTS-1:0]              m_cmd_ready,
  input  logic [PORTS*SEG_DATA_W-1:0]   m_resp_data,
  input  logic [PORTS-1:0]              m_resp_valid,
  output logic [PORTS-1:0]              m_resp_ready,
  output logic [$clog2(OUT_FIFO_DEPTH):0] credits_used,
  output logic [PORTS-1:0]              port_busy
);
  localparam int PW  = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CW  = $clog2(OUT_FIFO_DEPTH) + 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int OAW = $clog2(ORDER_FIFO_DEPTH);
  localparam int RAW = $clog2(OUT_FIFO_DEPTH);

  logic [PW-1:0] cmd_port;
  if (PORTS > 1) begin : g_sel
    assign cmd_port = s_cmd_sel[DMA_SEL_W-1 -: PW];
  end else begin : g_nosel
    assign cmd_port = '0;
  end

  // command skid buffer
  logic                  out_vld_q, out_vld_d, tmp_vld_q, tmp_vld_d;
  logic [PW-1:0]         out_port_q, out_port_d, tmp_port_q, tmp_port_d;
  logic [RAM_SEL_W-1:0]  out_sel_q, out_sel_d, tmp_sel_q, tmp_sel_d;
  logic [SEG_ADDR_W-1:0] out_addr_q, out_addr_d, tmp_addr_q, tmp_addr_d;

  // order FIFO and response FIFO pointers carry one wrap bit
  logic [PW-1:0]  ord_mem [ORDER_FIFO_DEPTH];
  logic [OAW:0]   ord_wr_q, ord_wr_d, ord_rd_q, ord_rd_d;
  logic [SEG_DATA_W-1:0] rf_mem [OUT_FIFO_DEPTH];
  logic [RAW:0]   rf_wr_q, rf_wr_d, rf_rd_q, rf_rd_d;

  logic                  s1_vld_q, s1_vld_d, rsp_vld_q, rsp_vld_d;
  logic [SEG_DATA_W-1:0] s1_dat_q, s1_dat_d, rsp_dat_q, rsp_dat_d;

  logic [CW-1:0]  credits_q, credits_d;
  logic [OW-1:0]  outstanding_q [PORTS];
  logic [OW-1:0]  outstanding_d [PORTS];
  logic [PORTS-1:0] port_busy_q, port_busy_d;

  logic          ord_full, ord_empty, rf_full, rf_empty;
  logic [PW-1:0] ord_head;
  logic          cmd_acc, out_hs, resp_hs, s_hs, rsp_free, s1_move, rf_pop;

  assign ord_empty = (ord_wr_q == ord_rd_q);
  assign ord_full  = (ord_wr_q[OAW] != ord_rd_q[OAW]) && (ord_wr_q[OAW-1:0] == ord_rd_q[OAW-1:0]);
  assign rf_empty  = (rf_wr_q == rf_rd_q);
  assign rf_full   = (rf_wr_q[RAW] != rf_rd_q[RAW]) && (rf_wr_q[RAW-1:0] == rf_rd_q[RAW-1:0]);
  assign ord_head  = ord_mem[ord_rd_q[OAW-1:0]];

  assign s_cmd_ready = !tmp_vld_q && !ord_full && (credits_q < CW'(OUT_FIFO_DEPTH))
                       && (outstanding_q[cmd_port] < OW'(MAX_OUTSTANDING));
  assign cmd_acc  = s_cmd_valid && s_cmd_ready;
  assign out_hs   = out_vld_q && m_cmd_ready[out_port_q];
  assign resp_hs  = !ord_empty && m_resp_valid[ord_head];
  assign s_hs     = rsp_vld_q && s_resp_ready;
  assign rsp_free = !rsp_vld_q || s_resp_ready;
  assign s1_move  = s1_vld_q && rsp_free;
  assign rf_pop   = !rf_empty && (!s1_vld_q || s1_move);

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      m_cmd_valid[i]  = out_vld_q && (out_port_q == PW'(i));
      m_resp_ready[i] = !ord_empty && (ord_head == PW'(i));
      m_cmd_sel[i*RAM_SEL_W +: RAM_SEL_W]    = out_sel_q;
      m_cmd_addr[i*SEG_ADDR_W +: SEG_ADDR_W] = out_addr_q;
    end
  end

  always_comb begin
    out_vld_d  = out_vld_q;  out_port_d = out_port_q;
    out_sel_d  = out_sel_q;  out_addr_d = out_addr_q;
    tmp_vld_d  = tmp_vld_q;  tmp_port_d = tmp_port_q;
    tmp_sel_d  = tmp_sel_q;  tmp_addr_d = tmp_addr_q;
    if (!out_vld_q || out_hs) begin
      if (tmp_vld_q) begin
        out_vld_d  = 1'b1;       out_port_d = tmp_port_q;
        out_sel_d  = tmp_sel_q;  out_addr_d = tmp_addr_q;
        tmp_vld_d  = 1'b0;
      end else begin
        out_vld_d = cmd_acc;
        if (cmd_acc) begin
          out_port_d = cmd_port;
          out_sel_d  = s_cmd_sel[RAM_SEL_W-1:0];
          out_addr_d = s_cmd_addr;
        end
      end
    end else if (cmd_acc) begin
      tmp_vld_d  = 1'b1;
      tmp_port_d = cmd_port;
      tmp_sel_d  = s_cmd_sel[RAM_SEL_W-1:0];
      tmp_addr_d = s_cmd_addr;
    end
  end

  always_comb begin
    ord_wr_d  = ord_wr_q + {{OAW{1'b0}}, cmd_acc};
    ord_rd_d  = ord_rd_q + {{OAW{1'b0}}, resp_hs};
    rf_wr_d   = rf_wr_q + {{RAW{1'b0}}, resp_hs};
    rf_rd_d   = rf_rd_q + {{RAW{1'b0}}, rf_pop};
    s1_vld_d  = rf_pop ? 1'b1 : (s1_move ? 1'b0 : s1_vld_q);
    s1_dat_d  = rf_pop ? rf_mem[rf_rd_q[RAW-1:0]] : s1_dat_q;
    rsp_vld_d = s1_move ? 1'b1 : (s_hs ? 1'b0 : rsp_vld_q);
    rsp_dat_d = s1_move ? s1_dat_q : rsp_dat_q;
    credits_d = credits_q;
    if (cmd_acc && !s_hs) credits_d = credits_q + CW'(1);
    else if (!cmd_acc && s_hs) credits_d = credits_q - CW'(1);
    for (int i = 0; i < PORTS; i++) begin
      outstanding_d[i] = outstanding_q[i];
      if ((cmd_acc && cmd_port == PW'(i)) && !(resp_hs && ord_head == PW'(i)))
        outstanding_d[i] = outstanding_q[i] + OW'(1);
      else if (!(cmd_acc && cmd_port == PW'(i)) && (resp_hs && ord_head == PW'(i)))
        outstanding_d[i] = outstanding_q[i] - OW'(1);
      port_busy_d[i] = (outstanding_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0; out_port_q <= '0; out_sel_q <= '0; out_addr_q <= '0;
      tmp_vld_q <= 1'b0; tmp_port_q <= '0; tmp_sel_q <= '0; tmp_addr_q <= '0;
      ord_wr_q <= '0; ord_rd_q <= '0; rf_wr_q <= '0; rf_rd_q <= '0;
      s1_vld_q <= 1'b0; s1_dat_q <= '0; rsp_vld_q <= 1'b0; rsp_dat_q <= '0;
      credits_q <= '0; port_busy_q <= '0;
      for (int i = 0; i < PORTS; i++) outstanding_q[i] <= '0;
    end else begin
      out_vld_q <= out_vld_d; out_port_q <= out_port_d; out_sel_q <= out_sel_d; out_addr_q <= out_addr_d;
      tmp_vld_q <= tmp_vld_d; tmp_port_q <= tmp_port_d; tmp_sel_q <= tmp_sel_d; tmp_addr_q <= tmp_addr_d;
      ord_wr_q <= ord_wr_d; ord_rd_q <= ord_rd_d; rf_wr_q <= rf_wr_d; rf_rd_q <= rf_rd_d;
      s1_vld_q <= s1_vld_d; s1_dat_q <= s1_dat_d; rsp_vld_q <= rsp_vld_d; rsp_dat_q <= rsp_dat_d;
      credits_q <= credits_d; port_busy_q <= port_busy_d;
      for (int i = 0; i < PORTS; i++) outstanding_q[i] <= outstanding_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_acc) ord_mem[ord_wr_q[OAW-1:0]] <= cmd_port;
    if (resp_hs) rf_mem[rf_wr_q[RAW-1:0]] <= m_resp_data[int'(ord_head)*SEG_DATA_W +: SEG_DATA_W];
  end

  // credits should make these impossible; firing means the accounting is broken
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(resp_hs && rf_full));
      assert (!(s_hs && !cmd_acc && credits_q == '0));
      assert (!(cmd_acc && !s_hs && credits_q == CW'(OUT_FIFO_DEPTH)));
      assert (!(resp_hs && outstanding_q[ord_head] == '0));
    end
  end

  assign s_resp_data  = rsp_dat_q;
  assign s_resp_valid = rsp_vld_q;
  assign credits_used = credits_q;
  assign port_busy    = port_busy_q;
endmodule

// File: tb/tb_taxi_dma_ram_demux_rd_cr.sv
// Randomised bench with a queue-based reference model of ordering, credits and per-port occupancy.
module tb_taxi_dma_ram_demux_rd_cr;
  localparam int PORTS = 4, AW = 12, DW = 64, SW = 4, RSW = 2, CW = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [SW-1:0]        s_cmd_sel;
  logic [AW-1:0]        s_cmd_addr;
  logic                 s_cmd_valid, s_cmd_ready;
  logic [DW-1:0]        s_resp_data;
  logic                 s_resp_valid, s_resp_ready;
  logic [PORTS*RSW-1:0] m_cmd_sel;
  logic [PORTS*AW-1:0]  m_cmd_addr;
  logic [PORTS-1:0]     m_cmd_valid, m_cmd_ready;
  logic [PORTS*DW-1:0]  m_resp_data;
  logic [PORTS-1:0]     m_resp_valid, m_resp_ready;
  logic [CW-1:0]        credits_used;
  logic [PORTS-1:0]     port_busy;

  taxi_dma_ram_demux_rd_cr dut (
    .clk(clk), .rst_n(rst_n),
    .s_cmd_sel(s_cmd_sel), .s_cmd_addr(s_cmd_addr), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_resp_data(s_resp_data), .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
    .m_cmd_sel(m_cmd_sel), .m_cmd_addr(m_cmd_addr), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_resp_data(m_resp_data), .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
    .credits_used(credits_used), .port_busy(port_busy)
  );

  typedef struct packed { logic [SW-1:0] sel; logic [AW-1:0] addr; } src_t;
  typedef struct packed { logic [1:0] port; logic [RSW-1:0] sel; logic [AW-1:0] addr; } iss_t;

  src_t          src_q[$];
  iss_t          iss_q[$];
  logic [1:0]    ord_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ram_mem [PORTS][64];
  int ram_wr[PORTS], ram_rd[PORTS], m_out[PORTS];
  int m_credits, n_acc, n_dlv, cyc, mresp_edge;
  logic [3:0] cmd_rdy_en, resp_en;
  logic rnd, cli_rdy, force_vld;
  logic [DW-1:0] force_dat;
  int tests, fails;

  task automatic drive();
    s_cmd_valid = (src_q.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
    if (src_q.size() > 0) begin
      s_cmd_sel = src_q[0].sel; s_cmd_addr = src_q[0].addr;
    end
    s_resp_ready = cli_rdy && (!rnd || $urandom_range(0, 3) != 0);
    for (int q = 0; q < PORTS; q++) begin
      m_cmd_ready[q]  = cmd_rdy_en[q] && (!rnd || $urandom_range(0, 3) != 0);
      m_resp_valid[q] = resp_en[q] && (ram_wr[q] != ram_rd[q]) && (!rnd || $urandom_range(0, 3) != 0);
      m_resp_data[q*DW +: DW] = (ram_wr[q] != ram_rd[q]) ? ram_mem[q][ram_rd[q] % 64] : '0;
    end
  endtask

  task automatic model_clear();
    src_q.delete(); iss_q.delete(); ord_q.delete(); exp_q.delete();
    for (int q = 0; q < PORTS; q++) begin ram_wr[q] = 0; ram_rd[q] = 0; m_out[q] = 0; end
    m_credits = 0;
  endtask

  // One clock: check invariants and record handshakes mid-cycle, then drive new inputs after the edge.
  task automatic tick();
    logic [3:0] exp_busy, exp_mrr;
    iss_t got;
    logic [DW-1:0] d;
    @(negedge clk);
    exp_busy = '0;
    for (int q = 0; q < PORTS; q++) exp_busy[q] = (m_out[q] != 0);
    exp_mrr = (ord_q.size() > 0) ? (4'b0001 << ord_q[0]) : 4'b0000;
    tests++; if (credits_used !== CW'(m_credits)) begin fails++; $display("FAIL credits: got %0d expected %0d", credits_used, m_credits); end
    tests++; if (port_busy !== exp_busy) begin fails++; $display("FAIL port_busy: got %b expected %b", port_busy, exp_busy); end
    tests++; if (m_resp_ready !== exp_mrr) begin fails++; $display("FAIL m_resp_ready: got %b expected %b", m_resp_ready, exp_mrr); end
    tests++; if ($countones(m_cmd_valid) > 1) begin fails++; $display("FAIL m_cmd_onehot: got %b expected at most one bit", m_cmd_valid); end
    for (int q = 0; q < PORTS; q++) begin
      if (m_cmd_valid[q] && m_cmd_ready[q]) begin
        got = {2'(q), m_cmd_sel[q*RSW +: RSW], m_cmd_addr[q*AW +: AW]};
        tests++;
        if (iss_q.size() == 0) begin fails++; $display("FAIL m_cmd_issue: got %h expected no command", got); end
        else begin
          if (got !== iss_q[0]) begin fails++; $display("FAIL m_cmd_issue: got %h expected %h", got, iss_q[0]); end
          void'(iss_q.pop_front());
        end
        d = force_vld ? force_dat : {$urandom, $urandom};
        ram_mem[q][ram_wr[q] % 64] = d; ram_wr[q]++;
        exp_q.push_back(d);
      end
      if (m_resp_valid[q] && m_resp_ready[q]) begin
        ram_rd[q]++; m_out[q]--; mresp_edge = cyc + 1;
        if (ord_q.size() > 0) void'(ord_q.pop_front());
      end
    end
    if (s_resp_valid && s_resp_ready) begin
      tests++;
      if (exp_q.size() == 0) begin fails++; $display("FAIL s_resp_data: got %h expected nothing", s_resp_data); end
      else begin
        if (s_resp_data !== exp_q[0]) begin fails++; $display("FAIL s_resp_data: got %h expected %h", s_resp_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      m_credits--; n_dlv++;
    end
    if (s_cmd_valid && s_cmd_ready) begin
      iss_q.push_back({s_cmd_sel[SW-1 -: 2], s_cmd_sel[RSW-1:0], s_cmd_addr});
      ord_q.push_back(s_cmd_sel[SW-1 -: 2]);
      m_out[s_cmd_sel[SW-1 -: 2]]++; m_credits++; n_acc++;
      void'(src_q.pop_front());
    end
    @(posedge clk); cyc++;
    #1; drive(); #1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      if (src_q.size() == 0 && iss_q.size() == 0 && ord_q.size() == 0 && exp_q.size() == 0 && m_credits == 0) break;
      tick();
    end
    tests++;
    if (i == budget) begin fails++; $display("FAIL %s_drain: got %0d words pending expected 0", name, exp_q.size() + src_q.size()); end
  endtask

  task automatic push_cmds(input int n, input int port);
    src_t c;
    for (int i = 0; i < n; i++) begin
      c.sel  = {(port < 0) ? 2'($urandom_range(0, 3)) : 2'(port), 2'($urandom_range(0, 3))};
      c.addr = AW'($urandom);
      src_q.push_back(c);
    end
  endtask

  task automatic test_reset();
    tests++; if (m_cmd_valid !== 4'b0000) begin fails++; $display("FAIL reset_m_cmd_valid: got %b expected 0000", m_cmd_valid); end
    tests++; if (s_resp_valid !== 1'b0) begin fails++; $display("FAIL reset_s_resp_valid: got %b expected 0", s_resp_valid); end
    tests++; if (credits_used !== '0) begin fails++; $display("FAIL reset_credits: got %0d expected 0", credits_used); end
    tests++; if (port_busy !== 4'b0000) begin fails++; $display("FAIL reset_port_busy: got %b expected 0000", port_busy); end
    tests++; if (m_resp_ready !== 4'b0000) begin fails++; $display("FAIL reset_m_resp_ready: got %b expected 0000", m_resp_ready); end
  endtask

  task automatic test_basic();
    src_t c;
    force_vld = 1'b1; force_dat = 64'hDEAD;
    c.sel = 4'hC; c.addr = 12'h123; src_q.push_back(c);
    tick();
    tests++; if (s_cmd_ready !== 1'b1) begin fails++; $display("FAIL basic_ready: got %b expected 1", s_cmd_ready); end
    tick();
    tests++; if (m_cmd_valid !== 4'b1000) begin fails++; $display("FAIL basic_m_cmd_valid: got %b expected 1000", m_cmd_valid); end
    tests++; if (m_cmd_sel[3*RSW +: RSW] !== 2'b00) begin fails++; $display("FAIL basic_m_cmd_sel: got %b expected 00", m_cmd_sel[3*RSW +: RSW]); end
    tests++; if (m_cmd_addr[3*AW +: AW] !== 12'h123) begin fails++; $display("FAIL basic_m_cmd_addr: got %h expected 123", m_cmd_addr[3*AW +: AW]); end
    for (int i = 0; i < 20 && !s_resp_valid; i++) tick();
    tests++; if (s_resp_valid !== 1'b1) begin fails++; $display("FAIL basic_resp_timeout: got %b expected 1", s_resp_valid); end
    tests++; if (cyc - mresp_edge !== 2) begin fails++; $display("FAIL basic_latency: got %0d edges expected 2", cyc - mresp_edge); end
    tests++; if (s_resp_data !== 64'hDEAD) begin fails++; $display("FAIL basic_data: got %h expected dead", s_resp_data); end
    wait_drain(20, "basic");
    tests++; if (credits_used !== '0) begin fails++; $display("FAIL basic_credits_end: got %0d expected 0", credits_used); end
    force_vld = 1'b0;
  endtask

  task automatic test_order();
    int base = n_dlv;
    resp_en = 4'b0000;
    push_cmds(1, 2); push_cmds(1, 0); push_cmds(1, 1);
    repeat (8) tick();
    tests++; if (iss_q.size() != 0) begin fails++; $display("FAIL order_issue: got %0d pending expected 0", iss_q.size()); end
    resp_en = 4'b0010; repeat (4) tick();
    tests++; if (n_dlv != base) begin fails++; $display("FAIL order_hold1: got %0d delivered expected %0d", n_dlv, base); end
    tests++; if (m_resp_ready !== 4'b0100) begin fails++; $display("FAIL order_head: got %b expected 0100", m_resp_ready); end
    resp_en = 4'b0011; repeat (4) tick();
    tests++; if (n_dlv != base) begin fails++; $display("FAIL order_hold2: got %0d delivered expected %0d", n_dlv, base); end
    resp_en = 4'b1111;
    wait_drain(30, "order");
    tests++; if (n_dlv - base != 3) begin fails++; $display("FAIL order_count: got %0d expected 3", n_dlv - base); end
  endtask

  task automatic test_credits();
    int a0 = n_acc, d0 = n_dlv;
    cli_rdy = 1'b0;
    push_cmds(20, -1);
    repeat (60) tick();
    tests++; if (n_acc - a0 != 16) begin fails++; $display("FAIL credit_accepted: got %0d expected 16", n_acc - a0); end
    tests++; if (s_cmd_ready !== 1'b0) begin fails++; $display("FAIL credit_ready: got %b expected 0", s_cmd_ready); end
    tests++; if (credits_used !== CW'(16)) begin fails++; $display("FAIL credit_used: got %0d expected 16", credits_used); end
    cli_rdy = 1'b1;
    wait_drain(200, "credit");
    tests++; if (n_dlv - d0 != 20) begin fails++; $display("FAIL credit_delivered: got %0d expected 20", n_dlv - d0); end
  endtask

  task automatic test_outstanding();
    int a0 = n_acc;
    resp_en = 4'b0111;
    push_cmds(9, 3);
    repeat (20) tick();
    tests++; if (n_acc - a0 != 8) begin fails++; $display("FAIL outst_accepted: got %0d expected 8", n_acc - a0); end
    tests++; if (port_busy !== 4'b1000) begin fails++; $display("FAIL outst_busy: got %b expected 1000", port_busy); end
    tests++; if (s_cmd_ready !== 1'b0) begin fails++; $display("FAIL outst_blocked: got %b expected 0", s_cmd_ready); end
    resp_en[3] = 1'b1; tick();
    resp_en[3] = 1'b0; tick();
    tests++; if (s_cmd_ready !== 1'b1) begin fails++; $display("FAIL outst_release: got %b expected 1", s_cmd_ready); end
    tick();
    tests++; if (n_acc - a0 != 9) begin fails++; $display("FAIL outst_ninth: got %0d expected 9", n_acc - a0); end
    resp_en = 4'b1111;
    wait_drain(60, "outst");
  endtask

  task automatic test_skid();
    int a0 = n_acc, d0 = n_dlv;
    cmd_rdy_en = 4'b1101;
    push_cmds(10, 1);
    repeat (6) tick();
    tests++; if (n_acc - a0 != 2) begin fails++; $display("FAIL skid_held: got %0d expected 2", n_acc - a0); end
    tests++; if (s_cmd_ready !== 1'b0) begin fails++; $display("FAIL skid_ready: got %b expected 0", s_cmd_ready); end
    tests++; if (m_cmd_valid !== 4'b0010) begin fails++; $display("FAIL skid_valid: got %b expected 0010", m_cmd_valid); end
    cmd_rdy_en = 4'b1111;
    repeat (11) tick();
    tests++; if (n_acc - a0 != 10) begin fails++; $display("FAIL skid_throughput: got %0d expected 10", n_acc - a0); end
    wait_drain(40, "skid");
    tests++; if (n_dlv - d0 != 10) begin fails++; $display("FAIL skid_delivered: got %0d expected 10", n_dlv - d0); end
  endtask

  task automatic test_reset_mid();
    int a0 = n_acc, d0;
    cli_rdy = 1'b0; resp_en = 4'b0000;
    push_cmds(6, -1);
    repeat (10) tick();
    tests++; if (n_acc - a0 != 6) begin fails++; $display("FAIL rstmid_accepted: got %0d expected 6", n_acc - a0); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (credits_used !== '0) begin fails++; $display("FAIL rstmid_credits: got %0d expected 0", credits_used); end
    tests++; if (port_busy !== 4'b0000) begin fails++; $display("FAIL rstmid_busy: got %b expected 0000", port_busy); end
    tests++; if (m_resp_ready !== 4'b0000) begin fails++; $display("FAIL rstmid_mrr: got %b expected 0000", m_resp_ready); end
    tests++; if (s_resp_valid !== 1'b0 || m_cmd_valid !== 4'b0000) begin fails++; $display("FAIL rstmid_valids: got %b/%b expected 0/0000", s_resp_valid, m_cmd_valid); end
    model_clear();
    cli_rdy = 1'b1; resp_en = 4'b1111;
    drive();
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    d0 = n_dlv;
    push_cmds(1, -1);
    wait_drain(30, "rstmid");
    tests++; if (n_dlv - d0 != 1) begin fails++; $display("FAIL rstmid_fresh: got %0d expected 1", n_dlv - d0); end
  endtask

  task automatic test_random();
    int a0 = n_acc, d0 = n_dlv;
    rnd = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (src_q.size() < 4 && $urandom_range(0, 1) == 1) push_cmds(1, -1);
      tick();
    end
    rnd = 1'b0;
    wait_drain(300, "random");
    tests++; if (n_dlv - d0 != n_acc - a0) begin fails++; $display("FAIL random_count: got %0d expected %0d", n_dlv - d0, n_acc - a0); end
  endtask

  initial begin
    tests = 0; fails = 0; n_acc = 0; n_dlv = 0; cyc = 0; mresp_edge = 0;
    rnd = 1'b0; cli_rdy = 1'b1; force_vld = 1'b0; force_dat = '0;
    cmd_rdy_en = 4'b1111; resp_en = 4'b1111;
    s_cmd_sel = '0; s_cmd_addr = '0;
    model_clear();
    drive();
    #23;
    test_reset();
    @(posedge clk); #2 rst_n = 1'b1;
    tick();
    test_basic();
    test_order();
    test_credits();
    test_outstanding();
    test_skid();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
